// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter that shares the single-port data memory between the core
// load/store port (0) and the loader/debug port (1), with registered memory strobes.
module data_memory_arbiter #(
    parameter int MEM_WORDS = 513
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        memReadDM,
    output logic        memWriteDM,
    output logic [31:0] addressDM,
    output logic [31:0] writeDataDM,
    input  logic [31:0] readDataDM,
    output logic        busy,
    output logic        owner
);

    localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic        lastOwner;
    logic        weQ;
    logic        badQ;

    logic        grantValid;
    logic        grantPort;
    logic        selWe;
    logic [31:0] selAddr;
    logic [31:0] selWdata;
    logic        selBad;

    // In DONE only the other port may be granted; the finishing port is still dropping its req.
    always_comb begin
        grantValid = 1'b0;
        grantPort  = 1'b0;
        if (state == IDLE) begin
            if (req0 && req1) begin
                grantValid = 1'b1;
                grantPort  = ~lastOwner;
            end else if (req0) begin
                grantValid = 1'b1;
                grantPort  = 1'b0;
            end else if (req1) begin
                grantValid = 1'b1;
                grantPort  = 1'b1;
            end
        end else if (state == DONE) begin
            if (owner ? req0 : req1) begin
                grantValid = 1'b1;
                grantPort  = ~owner;
            end
        end
    end

    always_comb begin
        selWe    = grantPort ? we1 : we0;
        selAddr  = grantPort ? addr1 : addr0;
        selWdata = grantPort ? wdata1 : wdata0;
        selBad   = (selAddr[1:0] != 2'b00) || (selAddr[31:2] >= WORD_LIMIT);
    end

    // addressDM/writeDataDM double as the latched request payload for the BUSY cycle.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            lastOwner   <= 1'b1;
            owner       <= 1'b0;
            weQ         <= 1'b0;
            badQ        <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            err0        <= 1'b0;
            err1        <= 1'b0;
            rdata0      <= 32'd0;
            rdata1      <= 32'd0;
            memReadDM   <= 1'b0;
            memWriteDM  <= 1'b0;
            addressDM   <= 32'd0;
            writeDataDM <= 32'd0;
            busy        <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            err0 <= 1'b0;
            err1 <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (grantValid) begin
                        state       <= BUSY;
                        owner       <= grantPort;
                        lastOwner   <= grantPort;
                        weQ         <= selWe;
                        badQ        <= selBad;
                        addressDM   <= selAddr;
                        writeDataDM <= selWdata;
                        memWriteDM  <= selWe & ~selBad;
                        memReadDM   <= ~selWe & ~selBad;
                        busy        <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                BUSY: begin
                    state      <= DONE;
                    memWriteDM <= 1'b0;
                    memReadDM  <= 1'b0;
                    if (owner) begin
                        ack1 <= 1'b1;
                        err1 <= badQ;
                        if (!weQ) begin
                            rdata1 <= badQ ? 32'd0 : readDataDM;
                        end
                    end else begin
                        ack0 <= 1'b1;
                        err0 <= badQ;
                        if (!weQ) begin
                            rdata0 <= badQ ? 32'd0 : readDataDM;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    memWriteDM <= 1'b0;
                    memReadDM  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter: a falling-edge-write memory model plus a
// scoreboard of expected completions popped whenever an ack appears.
module tb_data_memory_arbiter;

    localparam int MEM_WORDS = 513;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = 32'd0, addr1 = 32'd0;
    logic [31:0] wdata0 = 32'd0, wdata1 = 32'd0;
    logic        ack0, ack1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        memReadDM, memWriteDM;
    logic [31:0] addressDM, writeDataDM, readDataDM;
    logic        busy, owner;

    typedef struct {
        bit          port;
        bit          err;
        bit          chkData;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    exp_t        popped;
    int          vectors = 0;
    int          miscompares = 0;
    int          writeCount = 0;
    int          readCount = 0;
    int          ackCount = 0;
    logic [31:0] mem [0:MEM_WORDS-1];

    data_memory_arbiter #(.MEM_WORDS(MEM_WORDS)) dut (
        .clock(clock), .resetN(resetN),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata0(rdata0), .rdata1(rdata1),
        .memReadDM(memReadDM), .memWriteDM(memWriteDM),
        .addressDM(addressDM), .writeDataDM(writeDataDM), .readDataDM(readDataDM),
        .busy(busy), .owner(owner)
    );

    always #5 clock = ~clock;

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'd0;
    end

    always @(negedge clock) begin
        if (memWriteDM && addressDM[31:2] < MEM_WORDS) mem[addressDM[31:2]] <= writeDataDM;
    end

    assign readDataDM = (addressDM[31:2] < MEM_WORDS) ? mem[addressDM[31:2]] : 32'hDEADBEEF;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Every completion is matched against the oldest expectation the stimulus queued.
    always @(negedge clock) begin
        if (memWriteDM) writeCount++;
        if (memReadDM) readCount++;
        if (ack0 || ack1) begin
            ackCount++;
            checkOutput("ackOverlap", {31'd0, ack0 & ack1}, 32'd0);
            checkOutput("sbNonEmpty", {31'd0, sbq.size() > 0}, 32'd1);
            if (sbq.size() > 0) begin
                popped = sbq.pop_front();
                checkOutput("sbPort", {31'd0, ack1}, {31'd0, popped.port});
                checkOutput("sbErr", {31'd0, popped.port ? err1 : err0}, {31'd0, popped.err});
                if (popped.chkData)
                    checkOutput("sbRdata", popped.port ? rdata1 : rdata0, popped.data);
            end
        end
    end

    task automatic waitAck(input int port, output int n);
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!(port == 0 ? ack0 : (port == 1 ? ack1 : (ack0 | ack1))) && n < 20);
    endtask

    task automatic pushExp(input bit port, input bit err, input bit chk, input logic [31:0] data);
        exp_t e;
        e.port = port; e.err = err; e.chkData = chk; e.data = data;
        sbq.push_back(e);
    endtask

    task automatic applyStimulus(input bit port, input bit we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input bit expErr, input bit chk,
                                 input logic [31:0] expData);
        int n;
        pushExp(port, expErr, chk, expData);
        if (port) begin
            we1 = we; addr1 = addr; wdata1 = wdata; req1 = 1'b1;
        end else begin
            we0 = we; addr0 = addr; wdata0 = wdata; req0 = 1'b1;
        end
        waitAck(port, n);
        checkOutput("ackSeen", {31'd0, port ? ack1 : ack0}, 32'd1);
        checkOutput("latency", 32'(n), 32'd2);
        if (port) req1 = 1'b0; else req0 = 1'b0;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int n, w0, r0, a0, cnt0, cnt1;

        @(posedge clock);
        #1;
        checkOutput("rstAck0", {31'd0, ack0}, 32'd0);
        checkOutput("rstAck1", {31'd0, ack1}, 32'd0);
        checkOutput("rstErr", {30'd0, err0, err1}, 32'd0);
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstOwner", {31'd0, owner}, 32'd0);
        checkOutput("rstStrobes", {30'd0, memReadDM, memWriteDM}, 32'd0);
        checkOutput("rstRdata0", rdata0, 32'd0);
        checkOutput("rstRdata1", rdata1, 32'd0);
        checkOutput("rstAddrDM", addressDM, 32'd0);
        checkOutput("rstWdataDM", writeDataDM, 32'd0);
        @(posedge clock);
        #1;
        resetN = 1'b1;

        $display("[TB] port 0 write then read back");
        applyStimulus(1'b0, 1'b1, 32'd0, 32'h0000000D, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h0000000D);

        $display("[TB] simultaneous requests after reset");
        resetN = 1'b0;
        @(posedge clock);
        #1;
        resetN = 1'b1;
        pushExp(1'b0, 1'b0, 1'b0, 32'd0);
        pushExp(1'b1, 1'b0, 1'b1, 32'h00000007);
        we0 = 1'b1; addr0 = 32'd4; wdata0 = 32'h7; req0 = 1'b1;
        we1 = 1'b0; addr1 = 32'd4; req1 = 1'b1;
        waitAck(0, n);
        checkOutput("simAck0", {31'd0, ack0}, 32'd1);
        checkOutput("simAck0Lat", 32'(n), 32'd2);
        req0 = 1'b0;
        waitAck(1, n);
        checkOutput("simAck1", {31'd0, ack1}, 32'd1);
        checkOutput("simAck1Gap", 32'(n), 32'd2);
        req1 = 1'b0;
        @(posedge clock);
        #1;

        $display("[TB] payload held during BUSY");
        applyStimulus(1'b0, 1'b1, 32'd8, 32'h22, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'd12, 32'h33, 1'b0, 1'b0, 32'd0);
        pushExp(1'b0, 1'b0, 1'b1, 32'h22);
        we0 = 1'b0; addr0 = 32'd8; req0 = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("plReadStrobe", {31'd0, memReadDM}, 32'd1);
        checkOutput("plAddrEarly", addressDM, 32'd8);
        addr0 = 32'd12;
        @(negedge clock);
        checkOutput("plAddrMid", addressDM, 32'd8);
        @(posedge clock);
        #1;
        checkOutput("plAck", {31'd0, ack0}, 32'd1);
        req0 = 1'b0;
        @(posedge clock);
        #1;

        // Port 0 was served last, so port 1 takes the first of the eight alternating grants.
        $display("[TB] continuous two-port traffic");
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) pushExp(1'b1, 1'b0, 1'b1, 32'h22);
            else pushExp(1'b0, 1'b0, 1'b0, 32'd0);
        end
        cnt0 = 0; cnt1 = 0;
        we0 = 1'b1; addr0 = 32'd64; wdata0 = 32'h100; req0 = 1'b1;
        we1 = 1'b0; addr1 = 32'd8; req1 = 1'b1;
        for (int a = 0; a < 8; a++) begin
            waitAck(2, n);
            checkOutput("ctAckSeen", {31'd0, ack0 | ack1}, 32'd1);
            checkOutput(a == 0 ? "ctFirstLat" : "ctGap", 32'(n), 32'd2);
            if (ack0) begin
                cnt0++;
                if (cnt0 == 4) req0 = 1'b0;
                else begin
                    addr0 = 32'd64 + 32'(4 * cnt0);
                    wdata0 = 32'h100 + 32'(cnt0);
                end
            end
            if (ack1) begin
                cnt1++;
                if (cnt1 == 4) req1 = 1'b0;
            end
        end
        @(posedge clock);
        #1;
        checkOutput("ctWordWritten", mem[19], 32'h103);

        $display("[TB] rejected accesses");
        w0 = writeCount;
        applyStimulus(1'b1, 1'b1, 32'h6, 32'hBAD, 1'b1, 1'b0, 32'd0);
        checkOutput("badNoWrite", 32'(writeCount), 32'(w0));
        checkOutput("badMemUntouched", mem[1], 32'h7);
        r0 = readCount;
        applyStimulus(1'b1, 1'b0, 32'(4 * MEM_WORDS), 32'd0, 1'b1, 1'b1, 32'd0);
        checkOutput("badNoRead", 32'(readCount), 32'(r0));
        applyStimulus(1'b1, 1'b0, 32'(4 * (MEM_WORDS - 1)), 32'd0, 1'b0, 1'b1, 32'd0);

        $display("[TB] reset during a write");
        applyStimulus(1'b0, 1'b1, 32'd20, 32'hAAAA0000, 1'b0, 1'b0, 32'd0);
        we0 = 1'b1; addr0 = 32'd20; wdata0 = 32'h55; req0 = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("rstPreWrite", {31'd0, memWriteDM}, 32'd1);
        a0 = ackCount;
        #1;
        resetN = 1'b0;
        #1;
        checkOutput("rstWriteDrop", {31'd0, memWriteDM}, 32'd0);
        checkOutput("rstBusyDrop", {31'd0, busy}, 32'd0);
        req0 = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        resetN = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("rstNoAck", 32'(ackCount), 32'(a0));
        checkOutput("rstMemWord", mem[5], 32'hAAAA0000);
        applyStimulus(1'b0, 1'b0, 32'd20, 32'd0, 1'b0, 1'b1, 32'hAAAA0000);

        checkOutput("sbDrained", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
